ld_to_affine: RTL
=================

# ld_to_affine

Sequential converter that takes one Lopez-Dahab projective point (X, Y, Z) over GF(2^4) and returns the affine point x = X/Z, y = Y/Z^2. It sits directly downstream of the combinational point-addition stage and consumes its X2/Y2/Z2 outputs, so later stages see affine coordinates. The Z inverse is computed by a square-and-multiply chain (Z^-1 = Z^14) on one shared multiplier and one squarer.

## Interface
- No parameters. Field polynomial is fixed at x^4+x+1.
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  X/Y/Z valid
- in_ready  out  1  block can accept; high only in IDLE
- X  in  4  projective X
- Y  in  4  projective Y
- Z  in  4  projective Z
- out_valid  out  1  affine result valid; high only in DONE
- out_ready  in  1  consumer accepts result
- x_aff  out  4  affine x
- y_aff  out  4  affine y
- inf  out  1  point at infinity (Z == 0)

## Operation
- States: IDLE, INV1, INV2, INV3, INV4, INV5, MULX, MULY, DONE.
- IDLE: when in_valid && in_ready, latch X, Y, Z into xr, yr, zr. If Z == 0, go to DONE with inf=1, x_aff=0, y_aff=0. Otherwise go to INV1.
- Inversion chain, one operation per cycle, accumulator t:
  - INV1: t = zr^2
  - INV2: t = t·zr (Z^3)
  - INV3: t = t^2 (Z^6)
  - INV4: t = t·zr (Z^7)
  - INV5: t = t^2 (Z^14 = Z^-1)
- MULX: x_aff <= xr·t; t2 <= t^2, with the squarer running in parallel.
- MULY: y_aff <= yr·t2; inf <= 0.
- DONE: hold x_aff, y_aff, inf stable. On out_ready, go to IDLE.
- No new input is accepted while busy or in DONE; there is no overlap.
- All arithmetic is GF(2^4): addition is XOR, multiplication and squaring are reduced mod x^4+x+1. Every result is 4 bits with no carries.

## Timing
- Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, x_aff=0, y_aff=0, inf=0, internal registers 0.
- in_ready is combinational from state (IDLE). out_valid is combinational from state (DONE).
- Latency, counted from the accepting edge to the first cycle out_valid=1:
  - Z != 0: 8 cycles (7 compute states, then DONE).
  - Z == 0: 1 cycle.
- out_valid is held with stable data until out_ready. With out_ready tied high, the block returns to IDLE the cycle after DONE, giving a throughput of 1 point per 9 cycles.
- in_valid while not in IDLE is ignored. The producer must hold its data until in_ready.
- rst_n low in any state aborts immediately to reset values. The in-flight point is discarded and no partial out_valid is produced.

## Configuration
- LD2AFF_FAST_INV_EN defined:
  - INV1–INV5 are replaced by a single INVL state, t = inv_lut[zr], using a 16-entry constant table.
  - Z != 0 latency becomes 4 cycles (INVL, MULX, MULY, then DONE).
- LD2AFF_FAST_INV_EN undefined: the 5-step chain above, with latency 8.
- Interface and results are identical in both builds.

## Structure
- Package ld2aff_pkg holds:
  - state enum
  - field polynomial constant 5'b10011
  - 16×4 inverse table (used only under LD2AFF_FAST_INV_EN)
- Reuse the existing fourbit_MMult (one instance, operand muxed per state) and fourbit_SQR (one instance).
- No new sub-module is needed; FSM and datapath stay in ld_to_affine.

## Test plan
- X=1, Y=1, Z=2 → x_aff=9, y_aff=13, inf=0, out_valid exactly 8 cycles after accept (4 with LD2AFF_FAST_INV_EN).
- X=2, Y=2, Z=2 → x_aff=1, y_aff=9. Then X=5, Y=A, Z=1 → x_aff=5, y_aff=A.
- X=7, Y=3, Z=0 → inf=1, x_aff=0, y_aff=0, out_valid 1 cycle after accept.
- Back-pressure: out_ready low for 5 cycles in DONE → out_valid and data held constant, in_ready=0, in_valid pulses ignored. Then out_ready=1 → IDLE next cycle.
- Reset mid-op: assert rst_n=0 in INV3 → all outputs take reset values asynchronously. After release, a fresh X=1, Y=1, Z=2 still gives 9/13.
- Exhaustive: all 4096 (X, Y, Z) → compare against a model of X·Z^-1 and Y·Z^-2 mod x^4+x+1, in both builds.

Source files
------------

// File: rtl/ld2aff_pkg.sv
// ld2aff_pkg: shared types, field constants and GF(2^4) helpers for ld_to_affine
package ld2aff_pkg;

    typedef enum logic [3:0] {
        IDLE, INV1, INV2, INV3, INV4, INV5, INVL, MULX, MULY, DONE
    } state_t;

    localparam logic [4:0] FIELD_POLY = 5'b10011;

    // Multiplicative inverse of each field element; entry 0 maps to 0
    localparam logic [3:0] INV_LUT [16] = '{
        4'h0, 4'h1, 4'h9, 4'he, 4'hd, 4'hb, 4'h7, 4'h6,
        4'hf, 4'h2, 4'hc, 4'h5, 4'ha, 4'h4, 4'h3, 4'h8
    };

    // Shift-and-add multiply with reduction by FIELD_POLY on each shift
    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p;
        logic [3:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ aa;
            aa = aa[3] ? ({aa[2:0], 1'b0} ^ FIELD_POLY[3:0]) : {aa[2:0], 1'b0};
        end
        return p;
    endfunction

endpackage

// File: rtl/fourbit_MMult.sv
// fourbit_MMult: combinational GF(2^4) multiplier, reduced mod x^4+x+1
module fourbit_MMult
    import ld2aff_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] p
);

    assign p = gf_mul(a, b);

endmodule

// File: rtl/fourbit_SQR.sv
// fourbit_SQR: combinational GF(2^4) squarer, reduced mod x^4+x+1
module fourbit_SQR (
    input  logic [3:0] a,
    output logic [3:0] s
);

    // Squaring is linear: a0 + a1x^2 + a2x^4 + a3x^6 with x^4=x+1, x^6=x^3+x^2
    assign s = {a[3], a[1] ^ a[3], a[2], a[0] ^ a[2]};

endmodule

// File: rtl/ld_to_affine.sv
// ld_to_affine: Lopez-Dahab (X,Y,Z) to affine (X/Z, Y/Z^2) over GF(2^4); LD2AFF_FAST_INV_EN swaps the Z^14 chain for a table lookup
module ld_to_affine
    import ld2aff_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] X,
    input  logic [3:0] Y,
    input  logic [3:0] Z,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] x_aff,
    output logic [3:0] y_aff,
    output logic       inf
);

    state_t     state, nxt;
    logic [3:0] xr, yr, zr, t, t2;
    logic [3:0] ma, mb, mp, sa, sp;
    logic       acc;

    assign acc = in_valid && in_ready;

    // Steer the shared multiplier and squarer to the operands the current step needs
    always_comb begin
        ma = (state == MULX) ? xr : (state == MULY) ? yr : t;
        mb = (state == MULY) ? t2 : (state == MULX) ? t : zr;
        sa = (state == INV1) ? zr : t;
    end

    fourbit_MMult u_mul (.a(ma), .b(mb), .p(mp));
    fourbit_SQR   u_sqr (.a(sa), .s(sp));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    // Next-state: Z==0 skips straight to DONE as the point at infinity
    always_comb begin
        nxt = state;
        case (state)
            IDLE: if (acc) begin
`ifdef LD2AFF_FAST_INV_EN
                nxt = (Z == 4'd0) ? DONE : INVL;
`else
                nxt = (Z == 4'd0) ? DONE : INV1;
`endif
            end
            INV1: nxt = INV2;
            INV2: nxt = INV3;
            INV3: nxt = INV4;
            INV4: nxt = INV5;
            INV5: nxt = MULX;
            INVL: nxt = MULX;
            MULX: nxt = MULY;
            MULY: nxt = DONE;
            DONE: if (out_ready) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from state only
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Datapath: latch inputs, run the inversion steps, form the affine results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xr    <= '0;
            yr    <= '0;
            zr    <= '0;
            t     <= '0;
            t2    <= '0;
            x_aff <= '0;
            y_aff <= '0;
            inf   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (acc) begin
                    xr <= X;
                    yr <= Y;
                    zr <= Z;
                    if (Z == 4'd0) begin
                        x_aff <= '0;
                        y_aff <= '0;
                        inf   <= 1'b1;
                    end
                end
                INV1, INV3, INV5: t <= sp;
                INV2, INV4:       t <= mp;
`ifdef LD2AFF_FAST_INV_EN
                INVL: t <= INV_LUT[zr];
`endif
                MULX: begin
                    x_aff <= mp;
                    t2    <= sp;
                end
                MULY: begin
                    y_aff <= mp;
                    inf   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
